// File: rtl/operand_fetch.sv
// operand_fetch: register-file read and operand select, ahead of the ALU.
//
// It reads the rs1 and rs2 registers, with bypass from the writeback port
// in the same cycle. It picks operand B from the immediate or from rs2, and
// captures the result in a one-entry valid/ready output register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        handshake from decode
//   in_rs1, in_rs2             source register addresses
//   in_imm, in_use_imm         immediate and operand-B select
//   in_op, in_rd               opcode and destination, passed through
//   wb_en, wb_addr, wb_data    register-file write port
//   out_valid / out_ready      handshake toward the ALU
//   out_a, out_b, out_op, out_rd  registered operand bundle
module operand_fetch #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_op,
  output logic [4:0]       out_rd
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] regs_r [NREGS];
  logic [WIDTH-1:0] rs1_val_s;
  logic [WIDTH-1:0] rs2_val_s;
  logic [WIDTH-1:0] opb_s;
  logic             wr_en_s;
  logic             accept_s;

  // Register 0 is never written, so its flops stay at their reset value of 0.
  assign wr_en_s  = wb_en && (wb_addr != 5'd0);
  assign in_ready = (state_r == ST_EMPTY) || out_ready;
  assign accept_s = in_valid && in_ready;
  assign out_valid = (state_r == ST_FULL);

  // Register-file reads, with bypass of a same-cycle writeback.
  always_comb begin
    rs1_val_s = '0;
    rs2_val_s = '0;
    if (in_rs1 == 5'd0) begin
      rs1_val_s = '0;
    end else if (wb_en && (wb_addr == in_rs1)) begin
      rs1_val_s = wb_data;
    end else if (32'(in_rs1) < NREGS) begin
      rs1_val_s = regs_r[in_rs1];
    end else begin
      rs1_val_s = '0;
    end
    if (in_rs2 == 5'd0) begin
      rs2_val_s = '0;
    end else if (wb_en && (wb_addr == in_rs2)) begin
      rs2_val_s = wb_data;
    end else if (32'(in_rs2) < NREGS) begin
      rs2_val_s = regs_r[in_rs2];
    end else begin
      rs2_val_s = '0;
    end
    if (in_use_imm) begin
      opb_s = in_imm;
    end else begin
      opb_s = rs2_val_s;
    end
  end

  // Register-file storage. Writeback runs every cycle, whatever the
  // handshake state is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s && (32'(wb_addr) < NREGS)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Next state of the output stage. A simultaneous drain and accept keeps
  // the stage FULL.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else if (out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand bundle. Operands are captured only at accept and held
  // otherwise, so later writebacks do not disturb a stalled bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a  <= '0;
      out_b  <= '0;
      out_op <= 3'd0;
      out_rd <= 5'd0;
    end else if (accept_s) begin
      out_a  <= rs1_val_s;
      out_b  <= opb_s;
      out_op <= in_op;
      out_rd <= in_rd;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } bundle_t;

  bundle_t     exp_q[$];
  bundle_t     last_b;
  logic [31:0] ref_regs [32];
  int          pass_cnt;
  int          total_cnt;

  operand_fetch #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_op(in_op), .in_rd(in_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read: r0 reads zero, and a same-cycle write to the register
  // is forwarded.
  function automatic logic [31:0] ref_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_en && wb_addr == rs) return wb_data;
    return ref_regs[rs];
  endfunction

  task automatic clear_model();
    exp_q.delete();
    last_b = '{a: 32'd0, b: 32'd0, op: 3'd0, rd: 5'd0};
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    in_use_imm = 1'b0; in_op = 3'd0; in_rd = 5'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b0;
  endtask

  // One clock cycle of stimulus. The inputs are applied after the rising
  // edge. The model is updated late in the cycle, once the monitor has
  // seen any drain.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic use_imm, input logic [2:0] op,
                       input logic [4:0] rd, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy);
    logic    exp_rdy;
    bundle_t nb;
    @(posedge clk);
    #1;
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = use_imm;
    in_op = op; in_rd = rd; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #6;
    if (!rst_n) begin
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd1);
    end else begin
      exp_rdy = (exp_q.size() == 0) || ordy;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (v && exp_rdy) begin
        nb.a  = ref_read(rs1);
        nb.b  = use_imm ? imm : ref_read(rs2);
        nb.op = op;
        nb.rd = rd;
        exp_q.push_back(nb);
      end
      if (we && wa != 5'd0) ref_regs[wa] = wd;
    end
  endtask

  // Monitor. out_valid must match the scoreboard occupancy. The bundle on
  // the outputs must equal the head entry, or the last drained entry while
  // the stage is empty. The head is popped when the ALU takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_a", out_a, exp_q[0].a);
        chk("out_b", out_b, exp_q[0].b);
        chk("out_op", {29'd0, out_op}, {29'd0, exp_q[0].op});
        chk("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
        if (out_valid && out_ready) last_b = exp_q.pop_front();
      end else begin
        chk("hold_a", out_a, last_b.a);
        chk("hold_b", out_b, last_b.b);
        chk("hold_op", {29'd0, out_op}, {29'd0, last_b.op});
        chk("hold_rd", {27'd0, out_rd}, {27'd0, last_b.rd});
      end
    end
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    clear_model();
    set_idle();
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_op_rd", {24'd0, out_op, out_rd}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Write r5, then read it with rs2 = r0.
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 5'd5, 32'h0000_0010, 1'b1);
    drive(1'b1, 5'd5, 5'd0, 32'd0, 1'b0, 3'b010, 5'd1, 1'b0, 5'd0, 32'd0, 1'b1);
    // Bypass on rs1, and a write to r0 that must be discarded.
    drive(1'b1, 5'd7, 5'd0, 32'd0, 1'b0, 3'b100, 5'd2, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 32'd0, 1'b0, 3'b001, 5'd3, 1'b1, 5'd0, 32'h1234_5678, 1'b1);
    // The immediate replaces r3 as operand B.
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 5'd3, 32'd9, 1'b1);
    drive(1'b1, 5'd3, 5'd3, 32'hFFFF_FFFC, 1'b1, 3'b011, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b1, 5'd3, 5'd3, 32'hFFFF_FFFC, 1'b0, 3'b011, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    // Stall for three cycles while r5, the captured rs1, is overwritten,
    // then drain and accept in the same cycle.
    drive(1'b1, 5'd5, 5'd7, 32'd0, 1'b0, 3'b110, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 5'd5, 5'd3, 32'd0, 1'b0, 3'b111, 5'd10, 1'b1, 5'd5, 32'hA000_0000 + 32'(i), 1'b0);
    drive(1'b1, 5'd5, 5'd3, 32'd0, 1'b0, 3'b111, 5'd10, 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // 100 back-to-back instructions with random writebacks.
    for (int i = 0; i < 100; i++) begin
      logic [4:0] r1;
      r1 = 5'($urandom_range(0, 31));
      drive(1'b1, r1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31)), $urandom, 1'b1);
    end

    // Mixed traffic with random bubbles and back-pressure.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 2) != 0));
    end

    // Stall a bundle with non-zero contents, then assert reset between edges.
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b1, 5'd12, 32'h5555_AAAA, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b1, 5'd12, 5'd12, 32'd0, 1'b0, 3'b101, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b1, 5'd12, 5'd12, 32'd0, 1'b0, 3'b101, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_a", out_a, 32'd0);
    chk("async_rst_out_b", out_b, 32'd0);
    clear_model();
    // A writeback while reset is held must be ignored.
    drive(1'b1, 5'd9, 5'd9, 32'd0, 1'b0, 3'd1, 5'd1, 1'b1, 5'd9, 32'hFFFF_0000, 1'b1);
    @(posedge clk);
    #2;
    set_idle();
    #1 rst_n = 1'b1;
    // Every register must read 0 after release.
    for (int i = 0; i < 32; i++)
      drive(1'b1, 5'(i), 5'(31 - i), 32'd0, 1'b0, 3'd2, 5'(i), 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(posedge clk);
    #6;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: WIDTH, default 32, data width of registers, immediate and operands.
REQ-002 Parameter: NREGS, default 32, number of architectural registers; address width is 5 bits.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  decoded instruction present on in_* fields.
REQ-006 Port: in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 Port: in_rs1, in_rs2  input  5 each  source register addresses.
REQ-008 Port: in_imm  input  WIDTH  sign-extended immediate from decode.
REQ-009 Port: in_use_imm  input  1  1 selects in_imm as operand B, 0 selects register rs2.
REQ-010 Port: in_op  input  3  ALU opcode: and, or, add/sub on bit 2, slt; passed through unmodified.
REQ-011 Port: in_rd  input  5  destination register; passed through unmodified.
REQ-012 Port: wb_en, wb_addr, wb_data  input  1/5/WIDTH  register-file write port from writeback.
REQ-013 Port: out_valid  output  1  operand bundle valid toward the ALU stage.
REQ-014 Port: out_ready  input  1  ALU stage consumes the bundle this cycle.
REQ-015 Port: out_a, out_b  output  WIDTH each  ALU operands a and b.
REQ-016 Port: out_op, out_rd  output  3/5  registered copies of in_op and in_rd.

Function
REQ-017 Storage SHALL be NREGS x WIDTH flops; register 0 SHALL always read 0 and writes to it SHALL be discarded.
REQ-018 Write: when wb_en=1 and wb_addr!=0, wb_data SHALL be stored at wb_addr on the rising edge.
REQ-019 Read is combinational with bypass: if wb_en=1, wb_addr==rsX and rsX!=0, the value read SHALL be wb_data; otherwise the stored value.
REQ-020 Operand A SHALL be the value read for in_rs1; operand B SHALL be in_imm when in_use_imm=1, else the value read for in_rs2.
REQ-021 Output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 in_ready SHALL equal (state==EMPTY) or out_ready; combinational, no dependence on in_valid.
REQ-023 Accept occurs when in_valid and in_ready are both 1; on accept, out_a, out_b, out_op and out_rd SHALL load at the same edge; latency is 1 cycle.
REQ-024 Transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready=1 with no accept; FULL->FULL with new contents on simultaneous drain and accept; FULL->FULL, all out_* held, when out_ready=0.
REQ-025 While FULL and stalled, out_* SHALL NOT change even if a writeback targets a captured source register; operands are snapshotted at accept.
REQ-026 When no accept occurs, out_a, out_b, out_op and out_rd SHALL hold their last values, also in EMPTY.
REQ-027 Writeback SHALL proceed every cycle regardless of FSM state, in_valid or out_ready.
REQ-028 No hazard detection is performed; in-order writeback is the consumer's responsibility.

Reset
REQ-029 On rst_n=0, asynchronously: all registers SHALL be 0, state SHALL be EMPTY, out_valid=0, out_a=out_b=0, out_op=0, out_rd=0.
REQ-030 While rst_n=0, writeback SHALL be ignored and in_ready SHALL read 1; the first accept is allowed on the first rising edge after deassertion.
REQ-031 Reset asserted mid-stall SHALL discard the held bundle; no output is replayed after release.

Verification
REQ-032 Write r5=0x0000_0010, then accept rs1=5, rs2=0, use_imm=0, op=010, out_ready=1 -> next cycle out_valid=1, out_a=0x10, out_b=0, out_op=010.
REQ-033 Same cycle wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF with accept rs1=7 -> out_a=0xDEAD_BEEF (bypass); wb to r0 with rs1=0 -> out_a=0.
REQ-034 use_imm=1, imm=0xFFFF_FFFC, rs2=3 where r3=9 -> out_b=0xFFFF_FFFC.
REQ-035 Hold out_ready=0 for 3 cycles with in_valid=1, while wb writes the captured rs1 -> in_ready=0, out_* unchanged; on out_ready=1, drain and accept in the same cycle, out_valid stays 1.
REQ-036 Assert rst_n=0 asynchronously while FULL -> out_valid=0 and out_a=0 immediately, without waiting for a clock edge; every register reads 0 after release.
REQ-037 Stream 100 back-to-back instructions with out_ready=1 -> one bundle per cycle, in order, no bubbles, operands matching a reference register model.
